// File: rtl/demux_src.sv
`timescale 1ns/1ps
// demux_src: FIFO-buffered source driving a 4-phase bundled-data two-way demux.
// Optional per-branch completion counters (cnt_a/cnt_b) when DEMUX_SRC_CNT_EN is defined.
module demux_src #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SYNC  = 2,
  parameter int unsigned CW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_sel,
  output logic         r_o,
  output logic         ctl_a,
  output logic         ctl_b,
  output logic [N-1:0] d_o,
  input  logic         a_i,
  output logic         busy
`ifdef DEMUX_SRC_CNT_EN
  ,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC < 2 || CW < 1) begin : g_bad_param
    $error("demux_src: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_REQ, S_RTZ} state_t;

  state_t          r_state;
  logic [N:0]      r_mem [DEPTH];
  logic [AW:0]     r_wp;
  logic [AW:0]     r_rp;
  logic [SYNC-1:0] r_sync;
  logic            r_req;
  logic            r_ctl_a;
  logic            r_ctl_b;
  logic [N-1:0]    r_d;
`ifdef DEMUX_SRC_CNT_EN
  logic [CW-1:0]   r_cnt_a;
  logic [CW-1:0]   r_cnt_b;
`endif

  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_ack_s;
  logic [N:0] w_head;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  // Full is judged on registered pointers only, so a same-cycle pop never frees a slot.
  assign w_push  = in_valid && !w_full;
  assign w_ack_s = r_sync[SYNC-1];
  assign w_pop   = (r_state == S_REQ) && w_ack_s;
  assign w_head  = r_mem[r_rp[AW-1:0]];

  assign in_ready = !w_full;
  assign busy     = (r_state != S_IDLE) || !w_empty;
  assign r_o      = r_req;
  assign ctl_a    = r_ctl_a;
  assign ctl_b    = r_ctl_b;
  assign d_o      = r_d;
`ifdef DEMUX_SRC_CNT_EN
  assign cnt_a    = r_cnt_a;
  assign cnt_b    = r_cnt_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC-2:0], a_i};
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {in_sel, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_ctl_a <= 1'b0;
      r_ctl_b <= 1'b0;
      r_d     <= '0;
`ifdef DEMUX_SRC_CNT_EN
      r_cnt_a <= '0;
      r_cnt_b <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_d     <= w_head[N-1:0];
            r_ctl_a <= !w_head[N];
            r_ctl_b <= w_head[N];
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_ctl_a <= 1'b0;
            r_ctl_b <= 1'b0;
            r_state <= S_RTZ;
`ifdef DEMUX_SRC_CNT_EN
            if (r_ctl_b) r_cnt_b <= r_cnt_b + 1'b1;
            else         r_cnt_a <= r_cnt_a + 1'b1;
`endif
          end
        end
        S_RTZ: begin
          if (!w_ack_s) begin
            if (!w_empty) begin
              r_d     <= w_head[N-1:0];
              r_ctl_a <= !w_head[N];
              r_ctl_b <= w_head[N];
              r_state <= S_SETUP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_src.sv
`timescale 1ns/1ps
// tb_demux_src: randomized token stream against a queue model of the source; the bench plays the demux.
module tb_demux_src;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int CW    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_sel;
  logic         r_o, ctl_a, ctl_b;
  logic [N-1:0] d_o;
  logic         a_i;
  logic         busy;
`ifdef DEMUX_SRC_CNT_EN
  logic [CW-1:0] cnt_a, cnt_b;
`endif

  demux_src #(.N(N), .DEPTH(DEPTH), .SYNC(SYNC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .r_o(r_o), .ctl_a(ctl_a), .ctl_b(ctl_b), .d_o(d_o), .a_i(a_i),
    .busy(busy)
`ifdef DEMUX_SRC_CNT_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic sel; logic [N-1:0] data; } tok_t;

  tok_t stim[$];
  tok_t mq[$];
  tok_t last_tok;
  int   total = 0, bad = 0;
  bit   hold;
  int   rate, dly_lo, dly_hi, dly, wcnt;
  int   raise_cnt, drop_cnt, direct_hits;
  bit   drop_with_next;
  logic prev_r, prev_a, prev_b;
  logic [N-1:0] prev_d;
  int   acc_cnt, done_cnt, rise_cnt, m_cnt_a, m_cnt_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    raise_cnt++;
    drop_cnt++;
    if (!rst) begin
      if (prev_r && !r_o) begin
        chk("r_fall_latency", raise_cnt, SYNC + 1);
        chk("d_hold_at_fall", d_o, prev_d);
        if (mq.size() == 0) chk("pop_with_empty_model", 0, 1);
        else begin
          last_tok = mq.pop_front();
          done_cnt++;
          if (last_tok.sel) m_cnt_b++; else m_cnt_a++;
        end
      end
      if (!prev_r && r_o) begin
        rise_cnt++;
        chk("setup_ctl_a", prev_a, ctl_a);
        chk("setup_ctl_b", prev_b, ctl_b);
        chk("setup_d", prev_d, d_o);
        if (drop_with_next) begin
          chk("rtz_to_setup_latency", drop_cnt, SYNC + 2);
          direct_hits++;
        end
        drop_with_next = 0;
      end
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("rails_exclusive", ctl_a & ctl_b, 0);
      if (mq.size() > 0) chk("busy_nonempty", busy, 1);
      if (r_o) begin
        if (mq.size() == 0) chk("req_with_empty_model", 0, 1);
        else begin
          chk("d_o", d_o, mq[0].data);
          chk("ctl_a", ctl_a, !mq[0].sel);
          chk("ctl_b", ctl_b, mq[0].sel);
        end
      end
      if (a_i && !r_o) begin
        chk("rtz_rails", {ctl_a, ctl_b}, 0);
        chk("rtz_d_stable", d_o, last_tok.data);
      end
`ifdef DEMUX_SRC_CNT_EN
      chk("cnt_a", cnt_a, m_cnt_a % (1 << CW));
      chk("cnt_b", cnt_b, m_cnt_b % (1 << CW));
`endif
    end
    prev_r = r_o; prev_a = ctl_a; prev_b = ctl_b; prev_d = d_o;
    // demux responder: 4-phase ack with a per-phase random delay
    if (!hold && !rst) begin
      if (r_o && !a_i) begin
        if (wcnt >= dly) begin
          a_i = 1'b1; raise_cnt = 0; wcnt = 0; dly = $urandom_range(dly_hi, dly_lo);
        end else wcnt++;
      end else if (a_i && !r_o) begin
        if (wcnt >= dly) begin
          a_i = 1'b0; drop_cnt = 0; drop_with_next = (mq.size() > 0);
          wcnt = 0; dly = $urandom_range(dly_hi, dly_lo);
        end else wcnt++;
      end
    end
    if (!rst && stim.size() > 0 && $urandom_range(99, 0) < rate) begin
      in_valid = 1'b1;
      in_data  = stim[0].data;
      in_sel   = stim[0].sel;
      if (mq.size() < DEPTH) begin
        mq.push_back(stim.pop_front());
        acc_cnt++;
      end
    end else begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_sel   = 1'($urandom);
    end
  endtask

  task automatic clear_model();
    mq.delete(); stim.delete();
    a_i = 1'b0; in_valid = 1'b0; hold = 0; wcnt = 0;
    last_tok = '0; drop_with_next = 0;
    prev_r = 0; prev_a = 0; prev_b = 0; prev_d = '0;
    acc_cnt = 0; done_cnt = 0; rise_cnt = 0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic reset_now();
    #3 rst = 1'b1;
    #1;
    chk("rst_r_o", r_o, 0);
    chk("rst_ctl", {ctl_a, ctl_b}, 0);
    chk("rst_d_o", d_o, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((stim.size() > 0 || mq.size() > 0 || busy || a_i) && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) chk("drain_timeout", 1, 0);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_r_o", r_o, 0);
  endtask

  task automatic push_tok(input logic sel, input logic [N-1:0] data);
    tok_t t;
    t.sel = sel; t.data = data;
    stim.push_back(t);
  endtask

  initial begin
    int base, n;
    logic [7:0] sels;
    rst = 1'b1; in_data = '0; in_sel = 1'b0;
    clear_model();
    rate = 100; dly_lo = 0; dly_hi = 3; dly = 1;
    raise_cnt = 0; drop_cnt = 0; direct_hits = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) step();
    chk("init_in_ready", in_ready, 1);
    chk("init_busy", busy, 0);

    // stray ack pulse while idle must not start anything
    hold = 1; a_i = 1'b1;
    repeat (2) step();
    a_i = 1'b0;
    repeat (SYNC + 3) step();
    chk("stray_ack_r_o", r_o, 0);
    chk("stray_ack_busy", busy, 0);
    hold = 0;

    // single token, ack 3 cycles after r_o
    dly_lo = 3; dly_hi = 3; dly = 3; wcnt = 0;
    base = rise_cnt;
    push_tok(1'b0, 32'hA5A5_A5A5);
    step(); step(); step();
    chk("t2_ctl_a", ctl_a, 1);
    chk("t2_ctl_b", ctl_b, 0);
    chk("t2_d_o", d_o, 64'hA5A5_A5A5);
    chk("t2_r_o_setup", r_o, 0);
    step();
    chk("t2_r_o_req", r_o, 1);
    drain();
    chk("t2_one_handshake", rise_cnt - base, 1);
    chk("t2_d_after", d_o, 64'hA5A5_A5A5);

    // FIFO fill with ack held
    dly_lo = 0; dly_hi = 2;
    hold = 1; base = done_cnt;
    n = acc_cnt;
    for (int i = 0; i < 5; i++) push_tok(1'(i % 2), 32'h1000_0000 + i);
    repeat (8) step();
    chk("t3_in_ready_full", in_ready, 0);
    chk("t3_accepted", acc_cnt - n, 4);
    chk("t3_held", stim.size(), 1);
    hold = 0;
    drain();
    chk("t3_completed", done_cnt - base, 5);

    // back-to-back sel=1 then sel=0
    dly_lo = 1; dly_hi = 1; dly = 1;
    n = direct_hits;
    push_tok(1'b1, 32'hBBBB_0001);
    push_tok(1'b0, 32'hAAAA_0002);
    drain();
    chk("t4_direct_setup", direct_hits > n, 1);

    // reset while in REQ with tokens queued
    hold = 1;
    for (int i = 0; i < 3; i++) push_tok(1'($urandom), $urandom);
    n = 0;
    while (!r_o && n < 20) begin step(); n++; end
    chk("t5_reached_req", r_o, 1);
    reset_now();
    dly_lo = 0; dly_hi = 3;
    push_tok(1'b1, 32'h5EED_F00D);
    drain();
    chk("t5_post_reset_done", done_cnt, 1);

    // branch counters from a clean reset
    step();
    reset_now();
    sels = 8'b1111_0110;
    for (int i = 0; i < 8; i++) push_tok(sels[i], $urandom);
    drain();
    chk("t6_done", done_cnt, 8);
`ifdef DEMUX_SRC_CNT_EN
    chk("t6_cnt_a", cnt_a, 2);
    chk("t6_cnt_b", cnt_b, 2);
`endif

    // randomized stream
    rate = 60; dly_lo = 0; dly_hi = 4;
    base = done_cnt; n = acc_cnt;
    for (int i = 0; i < 300; i++) push_tok(1'($urandom), $urandom);
    drain();
    chk("rand_completed", done_cnt - base, 300);
    chk("rand_accepted", acc_cnt - n, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
